// File: rtl/tcm_lsu_master.sv
// tcm_lsu_master: load/store initiator for the data side of the tightly-coupled memory.
// Accepts one execute-stage request at a time and issues one TCM access for it.
// For stores, the write data is placed on the correct byte lanes.
// For loads, the returned lane is extracted and then sign- or zero-extended.
// Every output is driven straight from a register.
//
// Optional feature, macro LSU_MISALIGN_SPLIT_EN:
//   A misaligned load is split into two aligned word reads, and the two words are merged.
//   Misaligned stores always return an error, whether or not the macro is defined.
//
// Handshakes (strict valid/ready):
//   A transfer happens on a rising edge where valid and ready are both high.
//   A source that has raised valid keeps valid and its payload stable until that edge.
//   req_ready_o is high only in IDLE.
//   rsp_valid_o, rsp_rdata_o and rsp_err_o are held until rsp_ready_i is seen high.
module tcm_lsu_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [ADDR_W-1:0] tcm_addr_o,
    output logic              tcm_rd_o,
    output logic              tcm_we_o,
    output logic [2:0]        tcm_size_o,
    output logic [DATA_W-1:0] tcm_data_o,
    input  logic [DATA_W-1:0] tcm_data_i
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
`ifdef LSU_MISALIGN_SPLIT_EN
        ST_ISSUE2 = 3'd4,
        ST_WAIT2  = 3'd5,
`endif
        ST_RESP   = 3'd3
    } state_t;

    // One-hot TCM size code; the reserved size 11 is treated as a word.
    function automatic logic [2:0] size_onehot(input logic [1:0] sz);
        case (sz)
            2'b00:   size_onehot = 3'b001;
            2'b01:   size_onehot = 3'b010;
            default: size_onehot = 3'b100;
        endcase
    endfunction

    // Half needs an even address; word needs a 4-byte-aligned address.
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] ofs);
        case (sz)
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = ofs[0];
            default: is_misaligned = (ofs != 2'b00);
        endcase
    endfunction

    // Moves right-justified store data onto the byte lanes selected by the address.
    function automatic logic [31:0] lane_wdata(input logic [31:0] wd, input logic [1:0] sz,
                                               input logic [1:0] ofs);
        case (sz)
            2'b00:   lane_wdata = {24'h0, wd[7:0]} << {ofs, 3'b000};
            2'b01:   lane_wdata = {16'h0, wd[15:0]} << {ofs, 3'b000};
            default: lane_wdata = wd;
        endcase
    endfunction

    // Shifts the addressed bytes down to bit 0, truncates them and extends them.
    // The raw input is 64 bits wide so that a split access can pass {hi, lo}.
    function automatic logic [31:0] extend_load(input logic [63:0] raw, input logic [1:0] ofs,
                                                input logic [1:0] sz, input logic uns);
        logic [31:0] sh;
        sh = 32'(raw >> {ofs, 3'b000});
        case (sz)
            2'b00:   extend_load = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   extend_load = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: extend_load = sh;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        ofs_q, ofs_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [ADDR_W-1:0] tcm_addr_q, tcm_addr_d;
    logic              tcm_rd_q, tcm_rd_d;
    logic              tcm_we_q, tcm_we_d;
    logic [2:0]        tcm_size_q, tcm_size_d;
    logic [DATA_W-1:0] tcm_data_q, tcm_data_d;
    logic              req_fire;
    logic              req_mis;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic [ADDR_W-3:0] base_q, base_d;   // word index of the low word
    logic              split_q, split_d; // current load takes two reads
    logic [DATA_W-1:0] hold_q, hold_d;   // low word of a split load
`endif

    assign req_fire = req_valid_i && req_ready_q;
    assign req_mis  = is_misaligned(req_size_i, req_addr_i[1:0]);

    // Next-state and next-output logic.
    // Outputs are computed for the state being entered so that they can be registered.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        ofs_d       = ofs_q;
        size_d      = size_q;
        uns_d       = uns_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        tcm_addr_d  = '0;
        tcm_rd_d    = 1'b0;
        tcm_we_d    = 1'b0;
        tcm_size_d  = 3'b000;
        tcm_data_d  = '0;
`ifdef LSU_MISALIGN_SPLIT_EN
        base_d      = base_q;
        split_d     = split_q;
        hold_d      = hold_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_fire) begin
                    we_d   = req_we_i;
                    ofs_d  = req_addr_i[1:0];
                    size_d = req_size_i;
                    uns_d  = req_unsigned_i;
`ifdef LSU_MISALIGN_SPLIT_EN
                    base_d  = req_addr_i[ADDR_W-1:2];
                    split_d = 1'b0;
                    if (req_mis && req_we_i) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (req_mis) begin
                        // First half of a split load: the aligned word holding the low bytes.
                        split_d    = 1'b1;
                        state_d    = ST_ISSUE;
                        tcm_addr_d = {req_addr_i[ADDR_W-1:2], 2'b00};
                        tcm_size_d = 3'b100;
                        tcm_rd_d   = 1'b1;
                    end else begin
`else
                    if (req_mis) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
`endif
                        state_d    = ST_ISSUE;
                        tcm_addr_d = req_addr_i;
                        tcm_size_d = size_onehot(req_size_i);
                        if (req_we_i) begin
                            tcm_we_d   = 1'b1;
                            tcm_data_d = lane_wdata(req_wdata_i, req_size_i, req_addr_i[1:0]);
                        end else begin
                            tcm_rd_d = 1'b1;
                        end
                    end
                end
            end
            ST_ISSUE: begin
                if (we_q) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
`ifdef LSU_MISALIGN_SPLIT_EN
                if (split_q) begin
                    hold_d     = tcm_data_i;
                    state_d    = ST_ISSUE2;
                    tcm_addr_d = {base_q, 2'b00} + ADDR_W'(4);
                    tcm_size_d = 3'b100;
                    tcm_rd_d   = 1'b1;
                end else begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = extend_load({32'h0, tcm_data_i}, ofs_q, size_q, uns_q);
                end
`else
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = extend_load({32'h0, tcm_data_i}, ofs_q, size_q, uns_q);
`endif
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ST_ISSUE2: begin
                state_d = ST_WAIT2;
            end
            ST_WAIT2: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = extend_load({tcm_data_i, hold_q}, ofs_q, size_q, uns_q);
            end
`endif
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = rsp_rdata_q;
                    rsp_err_d   = rsp_err_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        req_ready_d = (state_d == ST_IDLE);
    end

    // State, latched request and registered outputs.
    // A reset clears them all and abandons any access in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            ofs_q       <= 2'b00;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            tcm_addr_q  <= '0;
            tcm_rd_q    <= 1'b0;
            tcm_we_q    <= 1'b0;
            tcm_size_q  <= 3'b000;
            tcm_data_q  <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            base_q      <= '0;
            split_q     <= 1'b0;
            hold_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            ofs_q       <= ofs_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            tcm_addr_q  <= tcm_addr_d;
            tcm_rd_q    <= tcm_rd_d;
            tcm_we_q    <= tcm_we_d;
            tcm_size_q  <= tcm_size_d;
            tcm_data_q  <= tcm_data_d;
`ifdef LSU_MISALIGN_SPLIT_EN
            base_q      <= base_d;
            split_q     <= split_d;
            hold_q      <= hold_d;
`endif
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign tcm_addr_o  = tcm_addr_q;
    assign tcm_rd_o    = tcm_rd_q;
    assign tcm_we_o    = tcm_we_q;
    assign tcm_size_o  = tcm_size_q;
    assign tcm_data_o  = tcm_data_q;

endmodule
